pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the Y86-64 five-stage pipeline. It sits beside the fetch, decode, execute, memory and write_back stages. It generates every stall, bubble and set_cc signal each cycle. Beyond the classic load/use, ret and mispredict logic it adds:
- a multi-cycle data-memory wait handshake with timeout,
- a registered run-state FSM that latches the terminating status,
- optional performance counters.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_perf_counters.sv | 92 +++++++++
 rtl/pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline encodings: icodes, status codes, RNONE
// and the run-state enum used by the hazard controller.
package pipe_pkg;

    localparam logic [3:0] IC_HALT   = 4'h0;
    localparam logic [3:0] IC_NOP    = 4'h1;
    localparam logic [3:0] IC_RRMOVQ = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_RMMOVQ = 4'h4;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_ADR = 2'd2;
    localparam logic [1:0] ST_INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        RS_RUN     = 2'd0,
        RS_MEMWAIT = 2'd1,
        RS_HALTED  = 2'd2
    } run_state_e;

endpackage

// File: rtl/pipe_perf_counters.sv
// Optional performance counters for the Y86-64 pipeline controller.
// Entire module exists only when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_counters
    import pipe_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int STAT_W  = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halted,
    input  logic               F_stall,
    input  logic               any_bubble,
    input  logic               W_bubble,
    input  logic               W_stall,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [STAT_W-1:0]  W_stat,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [ICODE_W-1:0] I_NOP  = ICODE_W'(IC_NOP);
    localparam logic [STAT_W-1:0]  S_AOK  = STAT_W'(ST_AOK);
    localparam logic [CNT_W-1:0]   ONE    = CNT_W'(1);

    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;
    logic               w_valid_q, w_valid_d;
    logic [ICODE_W-1:0] w_icode_q, w_icode_d;

    // Shadow of the W register (valid + icode) and next counter values.
    always_comb begin
        w_valid_d = w_valid_q;
        w_icode_d = w_icode_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        stall_d   = stall_q;
        bubble_d  = bubble_q;
        if (W_bubble) begin
            w_valid_d = 1'b0;
            w_icode_d = I_NOP;
        end else if (!W_stall) begin
            w_valid_d = 1'b1;
            w_icode_d = M_icode;
        end
        if (!halted) begin
            cycle_d = cycle_q + ONE;
        end
        if (!halted && w_valid_q && W_stat == S_AOK
            && w_icode_q != I_NOP) begin
            instr_d = instr_q + ONE;
        end
        if (F_stall) begin
            stall_d = stall_q + ONE;
        end
        if (any_bubble) begin
            bubble_d = bubble_q + ONE;
        end
    end

    // Counter and W-shadow registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instr_q   <= '0;
            stall_q   <= '0;
            bubble_q  <= '0;
            w_valid_q <= 1'b0;
            w_icode_q <= I_NOP;
        end else begin
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            stall_q   <= stall_d;
            bubble_q  <= bubble_d;
            w_valid_q <= w_valid_d;
            w_icode_q <= w_icode_d;
        end
    end

    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble/set_cc, memory-wait FSM.
// Counters added when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ICODE_W     = 4,
    parameter int REG_W       = 4,
    parameter int STAT_W      = 2,
    parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_Cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               dmem_busy,
    output logic               F_stall,
    output logic               D_stall,
    output logic               E_stall,
    output logic               M_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_bubble,
    output logic               set_cc,
    output logic [1:0]         run_state,
    output logic [STAT_W-1:0]  halt_code,
    output logic               mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    localparam logic [ICODE_W-1:0] I_RMMOVQ = ICODE_W'(IC_RMMOVQ);
    localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(IC_MRMOVQ);
    localparam logic [ICODE_W-1:0] I_OPQ    = ICODE_W'(IC_OPQ);
    localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(IC_JXX);
    localparam logic [ICODE_W-1:0] I_CALL   = ICODE_W'(IC_CALL);
    localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(IC_RET);
    localparam logic [ICODE_W-1:0] I_PUSHQ  = ICODE_W'(IC_PUSHQ);
    localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(IC_POPQ);

    localparam logic [STAT_W-1:0] S_AOK = STAT_W'(ST_AOK);
    localparam logic [STAT_W-1:0] S_ADR = STAT_W'(ST_ADR);

    localparam logic [REG_W-1:0] R_NONE = {REG_W{1'b1}};

    // Counter width holds 0..MEM_TIMEOUT; the last tolerated count
    // before the fault edge is MEM_TIMEOUT-1.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic loaduse;
    logic ret_haz;
    logic mispred;
    logic m_mem_op;
    logic memfreeze;
    logic m_fault;
    logic w_fault;

    run_state_e        state_q, state_d;
    logic [STAT_W-1:0] halt_code_q, halt_code_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign loaduse = (E_icode == I_MRMOVQ || E_icode == I_POPQ)
                  && E_dstM != R_NONE
                  && (E_dstM == d_srcA || E_dstM == d_srcB);

    assign ret_haz = D_icode == I_RET
                  || E_icode == I_RET
                  || M_icode == I_RET;

    assign mispred = E_icode == I_JXX && !e_Cnd;

    assign m_mem_op = M_icode == I_RMMOVQ
                   || M_icode == I_MRMOVQ
                   || M_icode == I_CALL
                   || M_icode == I_RET
                   || M_icode == I_PUSHQ
                   || M_icode == I_POPQ;

    assign m_fault   = m_stat != S_AOK;
    assign w_fault   = W_stat != S_AOK;
    assign memfreeze = dmem_busy && m_mem_op && !m_fault;

    // Stall/bubble/set_cc decode: reset, halted, freeze, then normal.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        E_stall  = 1'b0;
        M_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        set_cc   = 1'b0;
        if (reset) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_bubble = 1'b1;
        end else if (state_q == RS_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_stall = 1'b1;
            M_stall = 1'b1;
            W_stall = 1'b1;
        end else if (memfreeze) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            F_stall  = loaduse | ret_haz;
            D_stall  = loaduse;
            D_bubble = mispred | (ret_haz & !loaduse);
            E_bubble = mispred | loaduse;
            M_bubble = m_fault | w_fault;
            W_stall  = w_fault;
            set_cc   = E_icode == I_OPQ && !m_fault && !w_fault;
        end
    end

    // Run-state next state: W fault beats timeout; HALTED is sticky.
    always_comb begin
        state_d       = state_q;
        halt_code_d   = halt_code_q;
        mem_timeout_d = mem_timeout_q;
        wait_d        = wait_q;
        unique case (state_q)
            RS_RUN, RS_MEMWAIT: begin
                if (w_fault) begin
                    state_d     = RS_HALTED;
                    halt_code_d = W_stat;
                    wait_d      = '0;
                end else if (memfreeze) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d       = RS_HALTED;
                        halt_code_d   = S_ADR;
                        mem_timeout_d = 1'b1;
                        wait_d        = '0;
                    end else begin
                        state_d = RS_MEMWAIT;
                        wait_d  = wait_q + WAIT_ONE;
                    end
                end else begin
                    state_d = RS_RUN;
                    wait_d  = '0;
                end
            end
            RS_HALTED: begin
                state_d = RS_HALTED;
            end
            default: begin
                state_d = RS_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Run-state registers with synchronous reset back to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RS_RUN;
            halt_code_q   <= S_AOK;
            mem_timeout_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            halt_code_q   <= halt_code_d;
            mem_timeout_q <= mem_timeout_d;
            wait_q        <= wait_d;
        end
    end

    assign run_state   = state_q;
    assign halt_code   = halt_code_q;
    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_counters #(
        .ICODE_W (ICODE_W),
        .STAT_W  (STAT_W),
        .CNT_W   (CNT_W)
    ) u_perf (
        .clk        (clk),
        .reset      (reset),
        .halted     (state_q == RS_HALTED),
        .F_stall    (F_stall),
        .any_bubble (D_bubble | E_bubble | M_bubble | W_bubble),
        .W_bubble   (W_bubble),
        .W_stall    (W_stall),
        .M_icode    (M_icode),
        .W_stat     (W_stat),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Counter checks are built only with PIPE_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] D_icode, E_icode, M_icode;
    logic [3:0] d_srcA, d_srcB, E_dstM;
    logic       e_Cnd;
    logic [1:0] m_stat, W_stat;
    logic       dmem_busy;
    logic       F_stall, D_stall, E_stall, M_stall, W_stall;
    logic       D_bubble, E_bubble, M_bubble, W_bubble;
    logic       set_cc;
    logic [1:0] run_state;
    logic [1:0] halt_code;
    logic       mem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt, stall_cnt, bubble_cnt;
`endif

    logic [4:0] stl;
    logic [3:0] bub;
    assign stl = {F_stall, D_stall, E_stall, M_stall, W_stall};
    assign bub = {D_bubble, E_bubble, M_bubble, W_bubble};

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(
        .ICODE_W     (4),
        .REG_W       (4),
        .STAT_W      (2),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D_icode     (D_icode),
        .E_icode     (E_icode),
        .M_icode     (M_icode),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .E_dstM      (E_dstM),
        .e_Cnd       (e_Cnd),
        .m_stat      (m_stat),
        .W_stat      (W_stat),
        .dmem_busy   (dmem_busy),
        .F_stall     (F_stall),
        .D_stall     (D_stall),
        .E_stall     (E_stall),
        .M_stall     (M_stall),
        .W_stall     (W_stall),
        .D_bubble    (D_bubble),
        .E_bubble    (E_bubble),
        .M_bubble    (M_bubble),
        .W_bubble    (W_bubble),
        .set_cc      (set_cc),
        .run_state   (run_state),
        .halt_code   (halt_code),
        .mem_timeout (mem_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        D_icode   = 4'h1;
        E_icode   = 4'h1;
        M_icode   = 4'h1;
        d_srcA    = 4'hF;
        d_srcB    = 4'hF;
        E_dstM    = 4'hF;
        e_Cnd     = 1'b1;
        m_stat    = 2'd0;
        W_stat    = 2'd0;
        dmem_busy = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        reset  = 1'b1;
        W_stat = 2'd1;
        #1;
        checks++;
        if (bub !== 4'b1111) begin
            errors++;
            $display("FAIL rst_bubble got=%b exp=%b", bub, 4'b1111);
        end
        checks++;
        if (stl !== 5'b00000 || set_cc !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall got=%b/%b exp=00000/0", stl, set_cc);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({run_state, halt_code, mem_timeout} !== 5'b00_00_0) begin
            errors++;
            $display("FAIL rst_state got=%b exp=%b",
                     {run_state, halt_code, mem_timeout}, 5'b00_00_0);
        end
        @(negedge clk);
        idle();
        reset = 1'b0;
    endtask

    task automatic test_loaduse();
        @(negedge clk);
        idle();
        E_icode = 4'h5;
        E_dstM  = 4'h3;
        d_srcA  = 4'h3;
        #1;
        checks++;
        if (stl !== 5'b11000 || bub !== 4'b0100) begin
            errors++;
            $display("FAIL lu_mrmovq got=%b/%b exp=11000/0100", stl, bub);
        end
        @(negedge clk);
        idle();
        E_icode = 4'hB;
        E_dstM  = 4'h4;
        d_srcB  = 4'h4;
        #1;
        checks++;
        if (stl !== 5'b11000 || bub !== 4'b0100) begin
            errors++;
            $display("FAIL lu_popq got=%b/%b exp=11000/0100", stl, bub);
        end
        @(negedge clk);
        idle();
        E_icode = 4'h5;
        #1;
        checks++;
        if (stl !== 5'b00000 || bub !== 4'b0000) begin
            errors++;
            $display("FAIL lu_rnone got=%b/%b exp=00000/0000", stl, bub);
        end
        @(negedge clk);
        idle();
        E_icode = 4'h5;
        E_dstM  = 4'h2;
        d_srcA  = 4'h2;
        D_icode = 4'h9;
        #1;
        checks++;
        if (stl !== 5'b11000 || bub !== 4'b0100) begin
            errors++;
            $display("FAIL lu_ret got=%b/%b exp=11000/0100", stl, bub);
        end
    endtask

    task automatic test_mispred_ret();
        @(negedge clk);
        idle();
        E_icode = 4'h7;
        e_Cnd   = 1'b0;
        D_icode = 4'h9;
        #1;
        checks++;
        if (stl !== 5'b10000 || bub !== 4'b1100) begin
            errors++;
            $display("FAIL mispred got=%b/%b exp=10000/1100", stl, bub);
        end
        @(negedge clk);
        idle();
        E_icode = 4'h7;
        e_Cnd   = 1'b1;
        #1;
        checks++;
        if (stl !== 5'b00000 || bub !== 4'b0000) begin
            errors++;
            $display("FAIL jxx_taken got=%b/%b exp=00000/0000", stl, bub);
        end
        @(negedge clk);
        idle();
        M_icode = 4'h9;
        #1;
        checks++;
        if (stl !== 5'b10000 || bub !== 4'b1000) begin
            errors++;
            $display("FAIL ret_m got=%b/%b exp=10000/1000", stl, bub);
        end
    endtask

    task automatic test_set_cc();
        @(negedge clk);
        idle();
        E_icode = 4'h6;
        #1;
        checks++;
        if (set_cc !== 1'b1) begin
            errors++;
            $display("FAIL setcc_opq got=%b exp=1", set_cc);
        end
        @(negedge clk);
        m_stat = 2'd2;
        #1;
        checks++;
        if (set_cc !== 1'b0 || bub !== 4'b0010) begin
            errors++;
            $display("FAIL setcc_mfault got=%b/%b exp=0/0010", set_cc, bub);
        end
    endtask

    task automatic test_memwait();
        @(negedge clk);
        idle();
        M_icode   = 4'h5;
        dmem_busy = 1'b1;
        m_stat    = 2'd2;
        #1;
        checks++;
        if (stl !== 5'b00000 || bub !== 4'b0010) begin
            errors++;
            $display("FAIL nofreeze_adr got=%b/%b exp=00000/0010", stl, bub);
        end
        @(negedge clk);
        idle();
        M_icode   = 4'h6;
        dmem_busy = 1'b1;
        #1;
        checks++;
        if (stl !== 5'b00000 || run_state !== 2'd0) begin
            errors++;
            $display("FAIL nofreeze_opq got=%b/%0d exp=00000/0", stl, run_state);
        end
        @(negedge clk);
        idle();
        M_icode   = 4'h5;
        E_icode   = 4'h6;
        dmem_busy = 1'b1;
        #1;
        checks++;
        if (stl !== 5'b11110 || bub !== 4'b0001 || set_cc !== 1'b0
            || run_state !== 2'd0) begin
            errors++;
            $display("FAIL freeze_first got=%b/%b/%b/%0d exp=11110/0001/0/0",
                     stl, bub, set_cc, run_state);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (run_state !== 2'd1 || stl !== 5'b11110) begin
                errors++;
                $display("FAIL memwait_%0d got=%0d/%b exp=1/11110",
                         i, run_state, stl);
            end
        end
        @(negedge clk);
        dmem_busy = 1'b0;
        #1;
        checks++;
        if (run_state !== 2'd1 || stl !== 5'b00000 || set_cc !== 1'b1) begin
            errors++;
            $display("FAIL memwait_drop got=%0d/%b/%b exp=1/00000/1",
                     run_state, stl, set_cc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (run_state !== 2'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL memwait_run got=%0d/%b exp=0/0", run_state, mem_timeout);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        idle();
        M_icode   = 4'h5;
        E_icode   = 4'h6;
        dmem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                checks++;
                if (run_state !== 2'd1 || mem_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_before got=%0d/%b exp=1/0",
                             run_state, mem_timeout);
                end
            end
        end
        checks++;
        if (run_state !== 2'd2 || halt_code !== 2'd2 || mem_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_halt got=%0d/%0d/%b exp=2/2/1",
                     run_state, halt_code, mem_timeout);
        end
        checks++;
        if (stl !== 5'b11111 || bub !== 4'b0000 || set_cc !== 1'b0) begin
            errors++;
            $display("FAIL tmo_outs got=%b/%b/%b exp=11111/0000/0",
                     stl, bub, set_cc);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        idle();
        M_icode   = 4'h5;
        dmem_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        W_stat = 2'd3;
        @(posedge clk);
        #1;
        checks++;
        if (run_state !== 2'd2 || halt_code !== 2'd3 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL simul got=%0d/%0d/%b exp=2/3/0",
                     run_state, halt_code, mem_timeout);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        idle();
        W_stat = 2'd1;
        #1;
        checks++;
        if (stl !== 5'b00001 || bub !== 4'b0010) begin
            errors++;
            $display("FAIL halt_comb got=%b/%b exp=00001/0010", stl, bub);
        end
        @(posedge clk);
        #1;
        checks++;
        if (run_state !== 2'd2 || halt_code !== 2'd1 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL halt_state got=%0d/%0d/%b exp=2/1/0",
                     run_state, halt_code, mem_timeout);
        end
        checks++;
        if (stl !== 5'b11111 || bub !== 4'b0000) begin
            errors++;
            $display("FAIL halt_outs got=%b/%b exp=11111/0000", stl, bub);
        end
        @(negedge clk);
        W_stat = 2'd0;
        @(posedge clk);
        #1;
        checks++;
        if (run_state !== 2'd2 || halt_code !== 2'd1) begin
            errors++;
            $display("FAIL halt_sticky got=%0d/%0d exp=2/1", run_state, halt_code);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bub !== 4'b1111 || stl !== 5'b00000) begin
            errors++;
            $display("FAIL halt_rst_comb got=%b/%b exp=1111/00000", bub, stl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (run_state !== 2'd0 || halt_code !== 2'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL halt_rst got=%0d/%0d/%b exp=0/0/0",
                     run_state, halt_code, mem_timeout);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (stl !== 5'b00000 || bub !== 4'b0000) begin
            errors++;
            $display("FAIL halt_after got=%b/%b exp=00000/0000", stl, bub);
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_counters();
        @(negedge clk);
        idle();
        M_icode = 4'h6;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cycle_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_rst got=%0d/%0d exp=0/0", cycle_cnt, stall_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reset   = 1'b0;
            E_icode = (i == 4) ? 4'h5 : 4'h1;
            E_dstM  = (i == 4) ? 4'h3 : 4'hF;
            d_srcA  = 4'h3;
            @(posedge clk);
        end
        #1;
        checks++;
        if (cycle_cnt !== 32'd10) begin
            errors++;
            $display("FAIL cnt_cycle got=%0d exp=10", cycle_cnt);
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL cnt_stall got=%0d exp=1", stall_cnt);
        end
        checks++;
        if (bubble_cnt !== 32'd1) begin
            errors++;
            $display("FAIL cnt_bubble got=%0d exp=1", bubble_cnt);
        end
        checks++;
        if (instr_cnt !== 32'd9) begin
            errors++;
            $display("FAIL cnt_instr got=%0d exp=9", instr_cnt);
        end
    endtask
`endif

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_loaduse();
        test_mispred_ret();
        test_set_cc();
        test_memwait();
        test_timeout();
        test_simultaneous();
        test_halt();
`ifdef PIPE_PERF_CNT_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
